// File: rtl/fdtd_data_delay_line.sv
// Multi-lane programmable delay line aligning FDTD field operands ahead of the update engine.
// Depth 0..MAX_DELAY is set at run time; depth 0 is a combinational bypass.
module fdtd_data_delay_line #(
  parameter int unsigned FDTD_DATA_WIDTH = 32,
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned MAX_DELAY       = 16,
  parameter int unsigned DEFAULT_DELAY   = 2,
  parameter int unsigned DELAY_W         = $clog2(MAX_DELAY + 1)
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      en_i,
  input  logic                                      flush_i,
  input  logic                                      load_i,
  input  logic [DELAY_W-1:0]                        delay_i,
  input  logic                                      valid_i,
  input  logic [NUM_CHANNELS*FDTD_DATA_WIDTH-1:0]   data_i,
  output logic                                      valid_o,
  output logic [NUM_CHANNELS*FDTD_DATA_WIDTH-1:0]   data_o,
  output logic [DELAY_W-1:0]                        delay_o,
  output logic                                      primed_o,
  output logic                                      cfg_err_o
);

  localparam int unsigned BUS_W = NUM_CHANNELS * FDTD_DATA_WIDTH;
  localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] DEF_D = DELAY_W'(DEFAULT_DELAY);

  logic [MAX_DELAY-1:0] stage_valid;
  logic [BUS_W-1:0]     stage_data [MAX_DELAY];
  logic [DELAY_W-1:0]   delay_r;
  logic [DELAY_W-1:0]   fill_cnt;
  logic                 cfg_err_r;

  logic                 clear_c;
  logic                 req_too_big_c;
  logic [DELAY_W-1:0]   delay_sat_c;
  logic                 tap_valid_c;
  logic [BUS_W-1:0]     tap_data_c;

  assign clear_c       = load_i | flush_i;
  assign req_too_big_c = (delay_i > MAX_D);
  assign delay_sat_c   = req_too_big_c ? MAX_D : delay_i;

  // Stage storage, delay setting and fill tracking; load and flush both discard the edge's input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < MAX_DELAY; k++) begin
        stage_valid[k] <= 1'b0;
        stage_data[k]  <= '0;
      end
      delay_r   <= DEF_D;
      fill_cnt  <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      if (load_i) begin
        delay_r   <= delay_sat_c;
        cfg_err_r <= req_too_big_c;
      end
      if (clear_c) begin
        for (int unsigned k = 0; k < MAX_DELAY; k++) begin
          stage_valid[k] <= 1'b0;
          stage_data[k]  <= '0;
        end
        fill_cnt <= '0;
      end else if (en_i) begin
        stage_valid[0] <= valid_i;
        stage_data[0]  <= data_i;
        for (int unsigned k = 1; k < MAX_DELAY; k++) begin
          stage_valid[k] <= stage_valid[k-1];
          stage_data[k]  <= stage_data[k-1];
        end
        fill_cnt <= (fill_cnt < delay_r) ? (fill_cnt + DELAY_W'(1)) : delay_r;
      end
    end
  end

  // Output tap: stage[delay_r-1], selected only from registered state.
  always_comb begin
    tap_valid_c = 1'b0;
    tap_data_c  = '0;
    for (int unsigned k = 0; k < MAX_DELAY; k++) begin
      if (delay_r == DELAY_W'(k + 1)) begin
        tap_valid_c = stage_valid[k];
        tap_data_c  = stage_data[k];
      end
    end
  end

  assign valid_o   = (delay_r == '0) ? valid_i : tap_valid_c;
  assign data_o    = (delay_r == '0) ? data_i  : tap_data_c;
  assign delay_o   = delay_r;
  assign primed_o  = (fill_cnt == delay_r);
  assign cfg_err_o = cfg_err_r;

endmodule

// File: tb/tb_fdtd_data_delay_line.sv
// Scoreboard bench for fdtd_data_delay_line: the driver queues expected samples with their
// due advance-count, and a negedge monitor checks valid/data presented by the DUT.
module tb_fdtd_data_delay_line;

  localparam int unsigned DW   = 5;
  localparam int unsigned MAXD = 16;
  localparam int unsigned DEFD = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en_i = 1'b0, flush_i = 1'b0, load_i = 1'b0, valid_i = 1'b0;
  logic [DW-1:0] delay_i = '0;
  logic [63:0] data_i = '0;
  logic        valid_o, primed_o, cfg_err_o;
  logic [63:0] data_o;
  logic [DW-1:0] delay_o;

  always #5 CLK = ~CLK;

  fdtd_data_delay_line #(
    .FDTD_DATA_WIDTH(32), .NUM_CHANNELS(2), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
  ) dut (
    .CLK(CLK), .RST(RST), .en_i(en_i), .flush_i(flush_i), .load_i(load_i),
    .delay_i(delay_i), .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o),
    .data_o(data_o), .delay_o(delay_o), .primed_o(primed_o), .cfg_err_o(cfg_err_o)
  );

  typedef struct {
    logic [63:0] d;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned en_cnt   = 0;
  int unsigned m_delay  = DEFD;
  bit          adv_last = 1'b0;
  bit          last_v   = 1'b0;
  logic [63:0] last_d   = '0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] lanes(input logic [31:0] l0, input logic [31:0] l1);
    return {l1, l0};
  endfunction

  // Reference model of control state, updated on the same edge the DUT sees.
  always @(posedge CLK) begin
    if (RST) begin
      q.delete(); m_delay = DEFD; adv_last = 1'b0; last_v = 1'b0; last_d = '0;
    end else if (load_i) begin
      q.delete(); m_delay = (int'(delay_i) > MAXD) ? MAXD : int'(delay_i);
      adv_last = 1'b0; last_v = 1'b0; last_d = '0;
    end else if (flush_i) begin
      q.delete(); adv_last = 1'b0; last_v = 1'b0; last_d = '0;
    end else if (en_i) begin
      en_cnt++; adv_last = 1'b1;
    end else begin
      adv_last = 1'b0;
    end
  end

  // Monitor: after an advance (or in bypass) the tap must show the item due now; otherwise it holds.
  always @(negedge CLK) begin
    bit          ev;
    logic [63:0] ed;
    if (!RST) begin
      ev = 1'b0;
      ed = '0;
      if (m_delay == 0 || adv_last) begin
        if (q.size() > 0 && q[0].due == en_cnt) begin
          ev = 1'b1;
          ed = q[0].d;
        end
        chk("valid_o", 64'(valid_o), 64'(ev));
        if (ev) begin
          chk("data_o", data_o, ed);
          q.delete(0);
        end
        if (m_delay != 0) begin
          last_v = ev;
          last_d = ed;
        end
      end else begin
        chk("held valid_o", 64'(valid_o), 64'(last_v));
        if (last_v) chk("held data_o", data_o, last_d);
      end
    end
  end

  task automatic cycle(input bit rst, input bit en, input bit vld, input bit fl, input bit ld,
                       input int unsigned dly, input logic [63:0] d);
    exp_t e;
    @(posedge CLK); #1;
    RST = rst; en_i = en; valid_i = vld; flush_i = fl; load_i = ld;
    delay_i = DW'(dly); data_i = d;
    if (!rst && !fl && !ld && vld && (en || m_delay == 0)) begin
      e.d = d;
      e.due = en_cnt + m_delay;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [63:0] d);  cycle(0, 1, 1, 0, 0, 0, d);        endtask
  task automatic idle(input int n);           repeat (n) cycle(0, 1, 0, 0, 0, 0, 64'h0); endtask
  task automatic load(input int unsigned dly); cycle(0, 1, 0, 0, 1, dly, 64'h0); endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 64'h0);
    cycle(1, 0, 0, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 0, 64'h0);
    chk("reset valid_o", 64'(valid_o), 64'h0);
    chk("reset data_o", data_o, 64'h0);
    chk("reset delay_o", 64'(delay_o), 64'd2);
    chk("reset primed_o", 64'(primed_o), 64'h0);
    chk("reset cfg_err_o", 64'(cfg_err_o), 64'h0);

    // Default depth 2: stream 1..6, primed after the 2nd enabled edge
    send(lanes(32'd1, 32'h1000_0001));
    send(lanes(32'd2, 32'h1000_0002));
    chk("D2 primed after 1 edge", 64'(primed_o), 64'h0);
    send(lanes(32'd3, 32'h1000_0003));
    chk("D2 primed after 2 edges", 64'(primed_o), 64'h1);
    for (int i = 4; i <= 6; i++) send(lanes(32'(i), 32'h1000_0000 + 32'(i)));
    idle(3);

    // Depth 5, then an illegal request that saturates to 16
    load(5);
    send(64'hA0);
    chk("load5 delay_o", 64'(delay_o), 64'd5);
    chk("load5 cfg_err_o", 64'(cfg_err_o), 64'h0);
    chk("load5 primed_o", 64'(primed_o), 64'h0);
    for (int i = 1; i <= 3; i++) send(64'hA0 + 64'(i));
    idle(6);
    load(20);
    idle(1);
    chk("load20 delay_o", 64'(delay_o), 64'd16);
    chk("load20 cfg_err_o", 64'(cfg_err_o), 64'h1);
    send(64'hB0);
    send(64'hB1);
    idle(17);
    chk("cfg_err sticky over stream", 64'(cfg_err_o), 64'h1);
    cycle(0, 1, 0, 1, 0, 0, 64'h0);
    idle(1);
    chk("cfg_err sticky over flush", 64'(cfg_err_o), 64'h1);
    chk("flush keeps delay_o", 64'(delay_o), 64'd16);

    // Depth 3 with a 4-cycle stall mid-stream
    load(3);
    send(64'hC0);
    chk("load3 cfg_err cleared", 64'(cfg_err_o), 64'h0);
    chk("load3 delay_o", 64'(delay_o), 64'd3);
    send(64'hC1);
    send(64'hC2);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 64'h0);
    for (int i = 3; i <= 5; i++) send(64'hC0 + 64'(i));
    idle(4);

    // Depth 4 filled, then flush with valid input on the flush edge
    load(4);
    for (int i = 0; i < 6; i++) send(64'hD0 + 64'(i));
    chk("D4 primed when full", 64'(primed_o), 64'h1);
    cycle(0, 1, 1, 1, 0, 0, 64'hDEAD);
    idle(1);
    chk("flush valid_o", 64'(valid_o), 64'h0);
    chk("flush data_o", data_o, 64'h0);
    chk("flush primed_o", 64'(primed_o), 64'h0);
    chk("flush delay_o", 64'(delay_o), 64'd4);
    idle(6);

    // Depth 0 bypass, including a disabled cycle; then depth 1 with distinct lanes
    load(0);
    send(lanes(32'h1111_1111, 32'h2222_2222));
    chk("D0 delay_o", 64'(delay_o), 64'd0);
    chk("D0 primed_o", 64'(primed_o), 64'h1);
    send(lanes(32'h1111_0000, 32'h2222_0000));
    cycle(0, 0, 1, 0, 0, 0, lanes(32'h0000_1111, 32'h0000_2222));
    send(lanes(32'h1234_5678, 32'h9ABC_DEF0));
    load(1);
    send(lanes(32'h1111_1111, 32'h2222_2222));
    send(lanes(32'h3333_3333, 32'h4444_4444));
    send(lanes(32'h5555_5555, 32'h6666_6666));
    idle(2);

    // Reset mid-stream wins over a simultaneous load
    load(20);
    send(64'hE0);
    send(64'hE1);
    send(64'hE2);
    cycle(1, 1, 1, 0, 1, 7, 64'hE3);
    cycle(0, 0, 0, 0, 0, 0, 64'h0);
    chk("rst+load delay_o", 64'(delay_o), 64'd2);
    chk("rst+load cfg_err_o", 64'(cfg_err_o), 64'h0);
    chk("rst+load valid_o", 64'(valid_o), 64'h0);
    chk("rst+load data_o", data_o, 64'h0);
    chk("rst+load primed_o", 64'(primed_o), 64'h0);
    idle(20);
    chk("scoreboard drained", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
